// File: rtl/bus_mux_reg_pkg.sv
// Package: bus_mux_reg_pkg
// Shared definitions for the registered bus multiplexer and the blocks that use it
// (datapath top, control unit).
//   MODE_PRIORITY / MODE_STRICT : conflict-handling mode selectors
//   BUS_N / BUS_W               : default source count and data width
//   idx_width()                 : width of a source index, never less than 1

package bus_mux_reg_pkg;

    localparam int unsigned MODE_PRIORITY = 0;
    localparam int unsigned MODE_STRICT   = 1;

    localparam int unsigned BUS_N = 24;
    localparam int unsigned BUS_W = 32;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_mux_reg_prio_enc.sv
// Module: bus_mux_reg_prio_enc
// Combinational priority encoder over N drive requests; index 0 has highest priority.
//   e      in   N    drive requests
//   onehot out  N    lowest set bit of e, 0 if none
//   idx    out  IW   index of lowest set bit, 0 if none
//   any    out  1    at least one request
//   multi  out  1    two or more requests

module bus_mux_reg_prio_enc
    import bus_mux_reg_pkg::*;
#(
    parameter int unsigned N = BUS_N
) (
    input  logic [N-1:0]              e,
    output logic [N-1:0]              onehot,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      any,
    output logic                      multi
);

    localparam int unsigned IW = idx_width(N);

    always_comb begin
        // Two's-complement trick isolates the lowest set bit.
        onehot = e & (~e + N'(1));
        // Clearing the lowest set bit leaves something only if two or more were set.
        multi  = |(e & (e - N'(1)));
        any    = |e;
        idx    = '0;
        // Descending scan so the lowest set index is the last one written.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (e[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_mux_reg.sv
// Module: bus_mux_reg
// Registered N-source bus with priority arbitration and driver-conflict tracking.
//   clk             in   1     rising-edge clock
//   clr             in   1     asynchronous active-high reset
//   src_data        in   N*W   flattened sources, source i = src_data[i*W +: W]
//   src_out_en      in   N     per-source drive request
//   err_clr         in   1     synchronous clear of conflict_sticky / conflict_cnt
//   bus_out         out  W     registered bus value, holds when no source drives
//   bus_valid       out  1     bus_out was loaded from a source last cycle
//   grant           out  N     registered one-hot winner, 0 if none
//   src_idx         out  IW    registered winner index, 0 if none
//   conflict        out  1     more than one request last cycle
//   conflict_sticky out  1     any conflict since last clear
//   conflict_cnt    out  CW    saturating count of conflict cycles

module bus_mux_reg
    import bus_mux_reg_pkg::*;
#(
    parameter int unsigned N    = BUS_N,
    parameter int unsigned W    = BUS_W,
    parameter int unsigned CW   = 8,
    parameter int unsigned MODE = MODE_PRIORITY
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [N*W-1:0]           src_data,
    input  logic [N-1:0]             src_out_en,
    input  logic                     err_clr,
    output logic [W-1:0]             bus_out,
    output logic                     bus_valid,
    output logic [N-1:0]             grant,
    output logic [idx_width(N)-1:0]  src_idx,
    output logic                     conflict,
    output logic                     conflict_sticky,
    output logic [CW-1:0]            conflict_cnt
);

    localparam int unsigned IW = idx_width(N);
    localparam logic [CW-1:0] CntMax = {CW{1'b1}};

    logic [N-1:0]  win_oh;
    logic [IW-1:0] win_idx;
    logic          any_en;
    logic          multi_en;
    logic          blank;
    logic [W-1:0]  mux_data;

    logic [W-1:0]  bus_q;
    logic          valid_q;
    logic [N-1:0]  grant_q;
    logic [IW-1:0] idx_q;
    logic          conflict_q;
    logic          sticky_q;
    logic [CW-1:0] cnt_q;

    bus_mux_reg_prio_enc #(
        .N (N)
    ) u_prio_enc (
        .e      (src_out_en),
        .onehot (win_oh),
        .idx    (win_idx),
        .any    (any_en),
        .multi  (multi_en)
    );

    // Strict mode drives the bus to zero rather than pick a winner.
    assign blank = (MODE == MODE_STRICT) && multi_en;

    // AND-OR mux; win_oh is one-hot or zero so at most one slice contributes.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < int'(N); i++) begin
            mux_data = mux_data | (src_data[i*W +: W] & {W{win_oh[i]}});
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            idx_q   <= '0;
        end else if (blank) begin
            bus_q   <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            idx_q   <= '0;
        end else if (any_en) begin
            bus_q   <= mux_data;
            valid_q <= 1'b1;
            grant_q <= win_oh;
            idx_q   <= win_idx;
        end else begin
            // Idle: bus value holds, qualifiers drop.
            valid_q <= 1'b0;
            grant_q <= '0;
            idx_q   <= '0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            conflict_q <= 1'b0;
            sticky_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            conflict_q <= multi_en;
            if (multi_en) begin
                // A conflict on the clearing edge counts as the first after the clear.
                sticky_q <= 1'b1;
                if (err_clr) begin
                    cnt_q <= CW'(1);
                end else if (cnt_q != CntMax) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end else if (err_clr) begin
                sticky_q <= 1'b0;
                cnt_q    <= '0;
            end
        end
    end

    assign bus_out         = bus_q;
    assign bus_valid       = valid_q;
    assign grant           = grant_q;
    assign src_idx         = idx_q;
    assign conflict        = conflict_q;
    assign conflict_sticky = sticky_q;
    assign conflict_cnt    = cnt_q;

endmodule

// File: tb/tb_bus_mux_reg.sv
// Testbench: tb_bus_mux_reg
// Three instances share stimulus: priority mode (CW=8), strict mode (CW=8),
// and priority mode with a 2-bit conflict counter.

module tb_bus_mux_reg;

    localparam int unsigned N = 24;
    localparam int unsigned W = 32;

    logic           clk;
    logic           clr;
    logic [N*W-1:0] src_data;
    logic [N-1:0]   src_out_en;
    logic           err_clr;

    logic [W-1:0] bus0, bus1, bus2;
    logic         valid0, valid1, valid2;
    logic [N-1:0] grant0, grant1, grant2;
    logic [4:0]   idx0, idx1, idx2;
    logic         conf0, conf1, conf2;
    logic         sticky0, sticky1, sticky2;
    logic [7:0]   cnt0, cnt1;
    logic [1:0]   cnt2;

    int checks;
    int failures;

    bus_mux_reg #(.N(N), .W(W), .CW(8), .MODE(0)) dut_prio (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out_en(src_out_en),
        .err_clr(err_clr), .bus_out(bus0), .bus_valid(valid0), .grant(grant0),
        .src_idx(idx0), .conflict(conf0), .conflict_sticky(sticky0), .conflict_cnt(cnt0)
    );

    bus_mux_reg #(.N(N), .W(W), .CW(8), .MODE(1)) dut_strict (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out_en(src_out_en),
        .err_clr(err_clr), .bus_out(bus1), .bus_valid(valid1), .grant(grant1),
        .src_idx(idx1), .conflict(conf1), .conflict_sticky(sticky1), .conflict_cnt(cnt1)
    );

    bus_mux_reg #(.N(N), .W(W), .CW(2), .MODE(0)) dut_cw2 (
        .clk(clk), .clr(clr), .src_data(src_data), .src_out_en(src_out_en),
        .err_clr(err_clr), .bus_out(bus2), .bus_valid(valid2), .grant(grant2),
        .src_idx(idx2), .conflict(conf2), .conflict_sticky(sticky2), .conflict_cnt(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] en;
        logic [W-1:0] bus;
        logic         valid;
        logic [N-1:0] grant;
        logic [4:0]   idx;
        logic         conf;
        logic [W-1:0] s_bus;
        logic         s_valid;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input logic [W-1:0] v);
        src_data[i*W +: W] = v;
    endtask

    task automatic chk_zero0(input string tag);
        chk({tag, " bus"}, 64'(bus0), 64'h0);
        chk({tag, " valid"}, 64'(valid0), 64'h0);
        chk({tag, " grant"}, 64'(grant0), 64'h0);
        chk({tag, " idx"}, 64'(idx0), 64'h0);
        chk({tag, " conflict"}, 64'(conf0), 64'h0);
        chk({tag, " sticky"}, 64'(sticky0), 64'h0);
        chk({tag, " cnt"}, 64'(cnt0), 64'h0);
    endtask

    initial begin
        logic [W-1:0] mbus;
        logic [N-1:0] e;
        int           k;

        checks     = 0;
        failures   = 0;
        clr        = 1'b1;
        err_clr    = 1'b0;
        src_out_en = '0;
        src_data   = '0;
        for (int i = 0; i < int'(N); i++) set_src(i, 32'hC0DE_0000 | 32'(i));
        set_src(3, 32'h3333_3333);
        set_src(5, 32'h1234_5678);

        vecs[0] = '{24'h000020, 32'h1234_5678, 1, 24'h000020, 5,  0, 32'h1234_5678, 1};
        vecs[1] = '{24'h000000, 32'h1234_5678, 0, 24'h000000, 0,  0, 32'h1234_5678, 0};
        vecs[2] = '{24'h100008, 32'h3333_3333, 1, 24'h000008, 3,  1, 32'h0000_0000, 0};
        vecs[3] = '{24'h000000, 32'h3333_3333, 0, 24'h000000, 0,  0, 32'h0000_0000, 0};
        vecs[4] = '{24'h800000, 32'hC0DE_0017, 1, 24'h800000, 23, 0, 32'hC0DE_0017, 1};
        vecs[5] = '{24'h000001, 32'hC0DE_0000, 1, 24'h000001, 0,  0, 32'hC0DE_0000, 1};
        vecs[6] = '{24'hFFFFFF, 32'hC0DE_0000, 1, 24'h000001, 0,  1, 32'h0000_0000, 0};
        vecs[7] = '{24'hC00000, 32'hC0DE_0016, 1, 24'h400000, 22, 1, 32'h0000_0000, 0};
        vecs[8] = '{24'h001000, 32'hC0DE_000C, 1, 24'h001000, 12, 0, 32'hC0DE_000C, 1};

        // Reset state
        step();
        chk_zero0("reset");
        chk("reset strict bus", 64'(bus1), 64'h0);
        #2 clr = 1'b0;

        // Directed table
        foreach (vecs[v]) begin
            src_out_en = vecs[v].en;
            step();
            chk($sformatf("v%0d bus", v), 64'(bus0), 64'(vecs[v].bus));
            chk($sformatf("v%0d valid", v), 64'(valid0), 64'(vecs[v].valid));
            chk($sformatf("v%0d grant", v), 64'(grant0), 64'(vecs[v].grant));
            chk($sformatf("v%0d idx", v), 64'(idx0), 64'(vecs[v].idx));
            chk($sformatf("v%0d conflict", v), 64'(conf0), 64'(vecs[v].conf));
            chk($sformatf("v%0d strict bus", v), 64'(bus1), 64'(vecs[v].s_bus));
            chk($sformatf("v%0d strict valid", v), 64'(valid1), 64'(vecs[v].s_valid));
            chk($sformatf("v%0d strict grant", v), 64'(grant1),
                vecs[v].s_valid ? 64'(vecs[v].grant) : 64'h0);
            chk($sformatf("v%0d strict conflict", v), 64'(conf1), 64'(vecs[v].conf));
        end
        chk("table cnt", 64'(cnt0), 64'd3);
        chk("table sticky", 64'(sticky0), 64'h1);
        chk("table strict cnt", 64'(cnt1), 64'd3);

        // Mid-run asynchronous clear
        set_src(0, 32'hDEAD_BEEF);
        src_out_en = 24'h000001;
        step();
        chk("pre-clr bus", 64'(bus0), 64'hDEAD_BEEF);
        #3 clr = 1'b1;
        #1 chk_zero0("async clr");
        #2 clr = 1'b0;
        src_out_en = '0;
        step();
        chk("post-clr bus", 64'(bus0), 64'h0);
        chk("post-clr valid", 64'(valid0), 64'h0);

        // Saturating counter with CW=2
        src_out_en = 24'h000003;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("sat cnt %0d", i), 64'(cnt2), (i < 3) ? 64'(i + 1) : 64'd3);
            chk($sformatf("sat conflict %0d", i), 64'(conf2), 64'h1);
        end
        src_out_en = '0;
        err_clr    = 1'b1;
        step();
        chk("err_clr cnt", 64'(cnt2), 64'h0);
        chk("err_clr sticky", 64'(sticky2), 64'h0);
        src_out_en = 24'h000003;
        step();
        chk("err_clr+conf cnt", 64'(cnt2), 64'h1);
        chk("err_clr+conf sticky", 64'(sticky2), 64'h1);
        err_clr    = 1'b0;
        src_out_en = '0;
        step();
        chk("conflict pulse drop", 64'(conf2), 64'h0);

        // Random one-hot / idle traffic against a reference model
        mbus = bus0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < int'(N); i++) set_src(i, $urandom);
            k = $urandom_range(0, N);
            e = (k == int'(N)) ? '0 : (N'(1) << k);
            src_out_en = e;
            if (k != int'(N)) mbus = src_data[k*W +: W];
            step();
            chk("rnd bus", 64'(bus0), 64'(mbus));
            chk("rnd grant", 64'(grant0), 64'(e));
            chk("rnd idx", 64'(idx0), (k == int'(N)) ? 64'h0 : 64'(k));
            chk("rnd valid", 64'(valid0), (k == int'(N)) ? 64'h0 : 64'h1);
            chk("rnd conflict", 64'(conf0), 64'h0);
            chk("rnd strict bus", 64'(bus1), 64'(mbus));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
